// File: rtl/av_upload_pkg.sv
// av_upload_pkg: shared types and constants for the upload read path.
// Holds the FSM state enum, source index codes, fill byte and palette helper.
package av_upload_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } upload_state_t;

  localparam logic [5:0] IDX_CART0 = 6'd0;
  localparam logic [5:0] IDX_CART1 = 6'd1;
  localparam logic [5:0] IDX_PAL   = 6'd3;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Byte 0 of the palette is the most significant byte.
  function automatic logic [7:0] pal_byte(
    input logic [127:0] pal,
    input logic [3:0]   a
  );
    logic [127:0] s;
    s = pal << {a, 3'b000};
    return s[127:120];
  endfunction

endpackage

// File: rtl/av_upload_reader_if.sv
// av_upload_reader_if: host ioctl upload signals plus the cart RAM read port.
// master = host/RAM side, slave = av_upload_reader.
interface av_upload_reader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [11:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_dout,
    input  ioctl_din, ioctl_wait, ram_addr, ram_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_dout,
    output ioctl_din, ioctl_wait, ram_addr, ram_rd
  );
endinterface

// File: rtl/av_rd_delay.sv
// av_rd_delay: LAT-deep valid shift register; o_strobe fires LAT cycles
// after i_start. Ports: i_clk, i_rst, i_start, i_flush, o_strobe.
module av_rd_delay #(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_flush,
  output logic o_strobe
);

  logic [LAT-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_flush) begin
      r_sr <= '0;
    end else begin
      r_sr <= LAT'({r_sr, i_start});
    end
  end

  assign o_strobe = r_sr[LAT-1];

endmodule

// File: rtl/av_upload_reader.sv
// av_upload_reader: serves host upload reads from cart RAM or palette,
// holding ioctl_wait until the byte is valid. Ports: clk_sys, reset, bus
// (ioctl + RAM read port), palette_i, upload_active, overrun.
// Palette source is built only when AV_UPLOAD_PALETTE_EN is defined.
module av_upload_reader
  import av_upload_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int CART_SIZE   = 4096
) (
  input  logic                clk_sys,
  input  logic                reset,
  av_upload_reader_if.slave   bus,
  input  logic [127:0]        palette_i,
  output logic                upload_active,
  output logic                overrun
);

  localparam logic [24:0] LP_CART = 25'(CART_SIZE);

  upload_state_t r_state;
  upload_state_t w_next;

  logic [24:0] r_addr;
  logic [5:0]  r_idx;
  logic [11:0] r_ram_addr;
  logic [7:0]  r_byte;
  logic [7:0]  r_din;
  logic        r_from_ram;
  logic        r_upl;
  logic        r_ovr;

  logic        w_accept;
  logic        w_cart_ok;
  logic        w_strobe;
  logic [7:0]  w_sel;
  logic        w_unused;

  assign w_accept = (r_state == S_IDLE) & bus.ioctl_rd
                  & bus.ioctl_upload;

  // Range check uses the full address so high bits never alias.
  assign w_cart_ok = ((r_idx == IDX_CART0) | (r_idx == IDX_CART1))
                   & (r_addr < LP_CART);

  always_comb begin
    w_sel = FILL_BYTE;
`ifdef AV_UPLOAD_PALETTE_EN
    if ((r_idx == IDX_PAL) && (r_addr[24:4] == 21'd0)) begin
      w_sel = pal_byte(palette_i, r_addr[3:0]);
    end
`endif
  end

`ifdef AV_UPLOAD_PALETTE_EN
  assign w_unused = ^bus.ioctl_index[7:6];
`else
  assign w_unused = ^{bus.ioctl_index[7:6], palette_i};
`endif

  av_rd_delay #(
    .LAT (RAM_LATENCY)
  ) u_delay (
    .i_clk    (clk_sys),
    .i_rst    (reset),
    .i_start  (r_state == S_ISSUE),
    .i_flush  (~bus.ioctl_upload),
    .o_strobe (w_strobe)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!bus.ioctl_upload) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      if (bus.ioctl_rd) w_next = S_ISSUE;
        S_ISSUE:     w_next = S_WAIT_DATA;
        S_WAIT_DATA: if (w_strobe) w_next = S_DONE;
        S_DONE:      w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // DONE presents the byte with wait already released.
  always_comb begin
    bus.ioctl_wait = bus.ioctl_rd
                   | (r_state == S_ISSUE)
                   | (r_state == S_WAIT_DATA);
    bus.ram_rd     = (r_state == S_ISSUE) & w_cart_ok;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_idx      <= '0;
      r_ram_addr <= '0;
      r_byte     <= '0;
      r_din      <= '0;
      r_from_ram <= 1'b0;
      r_upl      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_upl <= bus.ioctl_upload;
      if (bus.ioctl_rd && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end
      if (w_accept) begin
        r_addr     <= bus.ioctl_addr;
        r_idx      <= bus.ioctl_index[5:0];
        r_ram_addr <= bus.ioctl_addr[11:0];
      end
      if (r_state == S_ISSUE) begin
        r_from_ram <= w_cart_ok;
        r_byte     <= w_sel;
      end
      if ((r_state == S_WAIT_DATA) && w_strobe
          && bus.ioctl_upload) begin
        r_din <= r_from_ram ? bus.ram_dout : r_byte;
      end
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ioctl_din = r_din;
  assign upload_active = r_upl;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_av_upload_reader.sv
// tb_av_upload_reader: directed bench for av_upload_reader at
// RAM_LATENCY 1 (u_dut1) and 3 (u_dut3), scoreboard of expected bytes.
module tb_av_upload_reader;

  localparam logic [127:0] PAL =
    128'h828214517356305A5F1A3B4900000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst3;
  logic up1, up3, ovr1, ovr3;

  av_upload_reader_if b1();
  av_upload_reader_if b3();

  av_upload_reader #(
    .RAM_LATENCY (1),
    .CART_SIZE   (4096)
  ) u_dut1 (
    .clk_sys       (clk),
    .reset         (rst1),
    .bus           (b1.slave),
    .palette_i     (PAL),
    .upload_active (up1),
    .overrun       (ovr1)
  );

  av_upload_reader #(
    .RAM_LATENCY (3),
    .CART_SIZE   (4096)
  ) u_dut3 (
    .clk_sys       (clk),
    .reset         (rst3),
    .bus           (b3.slave),
    .palette_i     (PAL),
    .upload_active (up3),
    .overrun       (ovr3)
  );

  logic [7:0] mem [4096];
  logic [7:0] p1, q1, q2, q3;

  // RAM models: data appears exactly LAT cycles after a ram_rd strobe.
  always @(posedge clk) p1 <= b1.ram_rd ? mem[b1.ram_addr] : 8'hEE;
  always @(posedge clk) begin
    q1 <= b3.ram_rd ? mem[b3.ram_addr] : 8'hEE;
    q2 <= q1;
    q3 <= q2;
  end
  assign b1.ram_dout = p1;
  assign b3.ram_dout = q3;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic [7:0] last1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pal_exp(input int a);
    logic [127:0] p;
    p = PAL;
    return p[127-8*a -: 8];
  endfunction

  // Entered just after a posedge; returns just after a posedge in IDLE.
  task automatic rd1(input logic [24:0] a, input logic [7:0] idx,
                     input logic [7:0] exp, input logic exp_ram);
    logic [7:0] e;
    sb.push_back(exp);
    b1.ioctl_addr  = a;
    b1.ioctl_index = idx;
    b1.ioctl_rd    = 1'b1;
    @(negedge clk); chk("req_wait", b1.ioctl_wait, 1);
    @(posedge clk); #1; b1.ioctl_rd = 1'b0;
    @(negedge clk); chk("ram_rd", b1.ram_rd, exp_ram);
    if (exp_ram) chk("ram_addr", b1.ram_addr, a[11:0]);
    @(negedge clk); chk("busy_wait", b1.ioctl_wait, 1);
    @(negedge clk); chk("done_wait", b1.ioctl_wait, 0);
    e = sb.pop_front();
    chk("din", b1.ioctl_din, e);
    last1 = e;
    @(posedge clk); #1;
  endtask

  task automatic rd3(input logic [24:0] a, input logic [7:0] exp);
    logic [7:0] e;
    sb.push_back(exp);
    b3.ioctl_addr  = a;
    b3.ioctl_index = 8'd0;
    b3.ioctl_rd    = 1'b1;
    @(posedge clk); #1; b3.ioctl_rd = 1'b0;
    @(negedge clk); chk("l3_ram_rd", b3.ram_rd, 1);
    repeat (3) @(negedge clk);
    chk("l3_busy_c4", b3.ioctl_wait, 1);
    @(negedge clk); chk("l3_done_wait", b3.ioctl_wait, 0);
    e = sb.pop_front();
    chk("l3_din", b3.ioctl_din, e);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 60);
    mem[12'h123] = 8'h5A;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.ioctl_upload = 1'b0; b1.ioctl_rd = 1'b1;
    b1.ioctl_addr = '0; b1.ioctl_index = '0;
    b3.ioctl_upload = 1'b1; b3.ioctl_rd = 1'b0;
    b3.ioctl_addr = '0; b3.ioctl_index = '0;
    last1 = 8'h00;

    // Reset state; wait follows ioctl_rd combinationally.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din", b1.ioctl_din, 8'h00);
    chk("rst_wait_rd", b1.ioctl_wait, 1);
    chk("rst_ram_rd", b1.ram_rd, 0);
    chk("rst_ram_addr", b1.ram_addr, 12'h000);
    chk("rst_ovr", ovr1, 0);
    chk("rst_up3", up3, 0);
    b1.ioctl_rd = 1'b0;
    #1 chk("rst_wait_idle", b1.ioctl_wait, 0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0;

    // ioctl_rd without upload is ignored.
    b1.ioctl_rd = 1'b1; b1.ioctl_addr = 25'h123;
    @(posedge clk); #1; b1.ioctl_rd = 1'b0;
    @(negedge clk);
    chk("noupl_wait", b1.ioctl_wait, 0);
    chk("noupl_ram_rd", b1.ram_rd, 0);
    chk("noupl_ovr", ovr1, 0);
    b1.ioctl_upload = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("upl_active", up1, 1);
    @(posedge clk); #1;

    // Cart reads and range boundaries.
    rd1(25'h123, 8'd0, 8'h5A, 1'b1);
    rd1(25'h000, 8'd1, mem[0], 1'b1);
    rd1(25'hFFF, 8'd0, mem[12'hFFF], 1'b1);
    rd1(25'd4096, 8'd1, 8'hFF, 1'b0);
    rd1(25'h1000123, 8'd0, 8'hFF, 1'b0);
    rd1(25'h000, 8'd7, 8'hFF, 1'b0);
    rd1(25'h045, 8'h41, mem[12'h045], 1'b1);

`ifdef AV_UPLOAD_PALETTE_EN
    rd1(25'h000, 8'd3, pal_exp(0), 1'b0);
    rd1(25'h005, 8'd3, pal_exp(5), 1'b0);
    rd1(25'h00F, 8'd3, pal_exp(15), 1'b0);
    rd1(25'h010, 8'd3, 8'hFF, 1'b0);
`else
    rd1(25'h000, 8'd3, 8'hFF, 1'b0);
    rd1(25'h005, 8'd3, 8'hFF, 1'b0);
`endif

    // Second ioctl_rd during ISSUE: overrun, first read still completes.
    sb.push_back(mem[12'h456]);
    b1.ioctl_addr = 25'h456; b1.ioctl_index = 8'd0; b1.ioctl_rd = 1'b1;
    @(posedge clk); #1;
    b1.ioctl_addr = 25'h007;
    @(negedge clk);
    chk("ovr_ram_addr", b1.ram_addr, 12'h456);
    chk("ovr_pre", ovr1, 0);
    @(posedge clk); #1; b1.ioctl_rd = 1'b0;
    @(negedge clk);
    chk("ovr_set", ovr1, 1);
    chk("ovr_addr_hold", b1.ram_addr, 12'h456);
    @(negedge clk);
    chk("ovr_done_wait", b1.ioctl_wait, 0);
    last1 = sb.pop_front();
    chk("ovr_din", b1.ioctl_din, last1);
    @(posedge clk); #1;
    rd1(25'h200, 8'd0, mem[12'h200], 1'b1);
    chk("ovr_sticky", ovr1, 1);

    // Upload dropped in WAIT_DATA: abort, din untouched.
    b1.ioctl_addr = 25'h123; b1.ioctl_index = 8'd0; b1.ioctl_rd = 1'b1;
    @(posedge clk); #1; b1.ioctl_rd = 1'b0;
    @(posedge clk); #1; b1.ioctl_upload = 1'b0;
    @(negedge clk); chk("abort_busy", b1.ioctl_wait, 1);
    @(negedge clk);
    chk("abort_wait", b1.ioctl_wait, 0);
    chk("abort_din", b1.ioctl_din, last1);
    chk("abort_upl", up1, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_din_hold", b1.ioctl_din, last1);
    b1.ioctl_upload = 1'b1;
    @(posedge clk); #1;
    rd1(25'h123, 8'd0, 8'h5A, 1'b1);

    // Latency 3: normal read, then async reset mid-request.
    rd3(25'h321, mem[12'h321]);
    b3.ioctl_addr = 25'h050; b3.ioctl_rd = 1'b1;
    @(posedge clk); #1; b3.ioctl_rd = 1'b0;
    @(posedge clk); #3;
    rst3 = 1'b1;
    #1;
    chk("arst_din", b3.ioctl_din, 8'h00);
    chk("arst_wait", b3.ioctl_wait, 0);
    chk("arst_ram_rd", b3.ram_rd, 0);
    chk("arst_ram_addr", b3.ram_addr, 12'h000);
    chk("arst_ovr", ovr3, 0);
    chk("arst_upl", up3, 0);
    @(posedge clk); #1; rst3 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("arst_no_replay_din", b3.ioctl_din, 8'h00);
    chk("arst_no_replay_wait", b3.ioctl_wait, 0);
    @(posedge clk); #1;
    rd3(25'h000, mem[0]);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
